// File: rtl/midi_parser.sv
// MIDI byte-stream parser: pops a FWFT receive FIFO and emits complete channel-voice events.
// Define MIDI_PARSER_RUNNING_STATUS_EN to honour running status across messages.
module midi_parser #(
  parameter logic [15:0] CHANNEL_MASK = 16'hFFFF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] fifo_dout,
  input  logic       fifo_empty,
  output logic       fifo_rd_en,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [2:0] evt_type,
  output logic [3:0] evt_channel,
  output logic [6:0] evt_data1,
  output logic [6:0] evt_data2
);

`ifdef MIDI_PARSER_RUNNING_STATUS_EN
  localparam bit RunningStatusEn = 1'b1;
`else
  localparam bit RunningStatusEn = 1'b0;
`endif

  typedef enum logic [1:0] {StWaitStatus, StWaitD1, StWaitD2} state_e;

  state_e     state_q, state_d;
  logic       rs_valid_q, rs_valid_d;
  logic [2:0] rs_type_q, rs_type_d;
  logic [3:0] rs_chan_q, rs_chan_d;
  logic [6:0] d1_q, d1_d;

  logic       evt_valid_q, evt_valid_d;
  logic [2:0] evt_type_q, evt_type_d;
  logic [3:0] evt_chan_q, evt_chan_d;
  logic [6:0] evt_d1_q, evt_d1_d;
  logic [6:0] evt_d2_q, evt_d2_d;

  logic       pop;
  logic       is_realtime, is_system, is_status;
  logic       take_d1, complete;
  logic [6:0] cmp_d1, cmp_d2;

  // A held, unaccepted event stalls the byte stream entirely.
  assign pop         = !reset && !fifo_empty && !(evt_valid_q && !evt_ready);
  assign is_realtime = (fifo_dout[7:3] == 5'h1F);
  assign is_system   = (fifo_dout[7:3] == 5'h1E);
  assign is_status   = fifo_dout[7] && (fifo_dout[7:4] != 4'hF);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StWaitStatus;
      rs_valid_q  <= 1'b0;
      rs_type_q   <= '0;
      rs_chan_q   <= '0;
      d1_q        <= '0;
      evt_valid_q <= 1'b0;
      evt_type_q  <= '0;
      evt_chan_q  <= '0;
      evt_d1_q    <= '0;
      evt_d2_q    <= '0;
    end else begin
      state_q     <= state_d;
      rs_valid_q  <= rs_valid_d;
      rs_type_q   <= rs_type_d;
      rs_chan_q   <= rs_chan_d;
      d1_q        <= d1_d;
      evt_valid_q <= evt_valid_d;
      evt_type_q  <= evt_type_d;
      evt_chan_q  <= evt_chan_d;
      evt_d1_q    <= evt_d1_d;
      evt_d2_q    <= evt_d2_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rs_valid_d = rs_valid_q;
    rs_type_d  = rs_type_q;
    rs_chan_d  = rs_chan_q;
    d1_d       = d1_q;
    take_d1    = 1'b0;
    complete   = 1'b0;
    cmp_d1     = d1_q;
    cmp_d2     = '0;
    if (pop && !is_realtime) begin
      if (is_system) begin
        rs_valid_d = 1'b0;
        state_d    = StWaitStatus;
      end else if (is_status) begin
        rs_valid_d = 1'b1;
        rs_type_d  = fifo_dout[6:4];
        rs_chan_d  = fifo_dout[3:0];
        state_d    = StWaitD1;
      end else begin
        unique case (state_q)
          StWaitStatus: take_d1 = RunningStatusEn && rs_valid_q;
          StWaitD1:     take_d1 = 1'b1;
          StWaitD2: begin
            complete = 1'b1;
            cmp_d2   = fifo_dout[6:0];
          end
          default:      state_d = StWaitStatus;
        endcase
        if (take_d1) begin
          d1_d   = fifo_dout[6:0];
          cmp_d1 = fifo_dout[6:0];
          if (rs_type_q == 3'd4 || rs_type_q == 3'd5) begin
            complete = 1'b1;
          end else begin
            state_d = StWaitD2;
          end
        end
        if (complete) begin
          state_d = StWaitStatus;
          if (!RunningStatusEn) rs_valid_d = 1'b0;
        end
      end
    end
  end

  always_comb begin
    evt_valid_d = evt_valid_q;
    evt_type_d  = evt_type_q;
    evt_chan_d  = evt_chan_q;
    evt_d1_d    = evt_d1_q;
    evt_d2_d    = evt_d2_q;
    if (evt_valid_q && evt_ready) evt_valid_d = 1'b0;
    if (complete && CHANNEL_MASK[rs_chan_q]) begin
      evt_valid_d = 1'b1;
      // Note-on with velocity 0 is reported as note-off.
      evt_type_d  = (rs_type_q == 3'd1 && cmp_d2 == 7'd0) ? 3'd0 : rs_type_q;
      evt_chan_d  = rs_chan_q;
      evt_d1_d    = cmp_d1;
      evt_d2_d    = cmp_d2;
    end
  end

  assign fifo_rd_en  = pop;
  assign evt_valid   = evt_valid_q;
  assign evt_type    = evt_type_q;
  assign evt_channel = evt_chan_q;
  assign evt_data1   = evt_d1_q;
  assign evt_data2   = evt_d2_q;

endmodule

// File: tb/tb_midi_parser.sv
// Bench for midi_parser: FWFT FIFO model, byte-count reference parser, directed and random streams.
module tb_midi_parser;

  localparam logic [15:0] Mask = 16'h7FF7;  // channels 3 and 15 dropped

  typedef struct packed {
    logic [2:0] t;
    logic [3:0] ch;
    logic [6:0] d1;
    logic [6:0] d2;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] fifo_dout;
  logic       fifo_empty;
  logic       fifo_rd_en;
  logic       evt_valid;
  logic       evt_ready;
  logic [2:0] evt_type;
  logic [3:0] evt_channel;
  logic [6:0] evt_data1;
  logic [6:0] evt_data2;

  logic [7:0] fq[$];
  logic [7:0] stim[$];
  ev_t        exp_q[$];
  ev_t        obs_q[$];

  int checks, failures;
  int pops, first_pop, last_pop, valid_cnt, first_valid, stall_viol, stall_cycles;
  bit timed_out;

  midi_parser #(.CHANNEL_MASK(Mask)) dut (
    .clk        (clk),
    .reset      (reset),
    .fifo_dout  (fifo_dout),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .evt_type   (evt_type),
    .evt_channel(evt_channel),
    .evt_data1  (evt_data1),
    .evt_data2  (evt_data2)
  );

  always #5 clk = ~clk;

  task automatic load(input logic [7:0] b);
    fq.push_back(b);
    stim.push_back(b);
  endtask

  // Reference: collect data bytes behind the last channel status, emit when enough arrive.
  task automatic model();
    bit         have;
    logic [2:0] t;
    logic [3:0] ch;
    logic [6:0] dbuf[2];
    int         nd, need;
    ev_t        e;
    exp_q.delete();
    have = 0; nd = 0; t = '0; ch = '0;
    foreach (stim[i]) begin
      logic [7:0] b;
      b = stim[i];
      if (b >= 8'hF8) continue;
      if (b >= 8'hF0) begin have = 0; nd = 0; continue; end
      if (b >= 8'h80) begin have = 1; t = b[6:4]; ch = b[3:0]; nd = 0; continue; end
      if (!have) continue;
      dbuf[nd] = b[6:0];
      nd++;
      need = (t == 3'd4 || t == 3'd5) ? 1 : 2;
      if (nd == need) begin
        e.t  = t;
        e.ch = ch;
        e.d1 = dbuf[0];
        e.d2 = (need == 2) ? dbuf[1] : 7'd0;
        if (e.t == 3'd1 && e.d2 == 7'd0) e.t = 3'd0;
        if (Mask[ch]) exp_q.push_back(e);
        nd = 0;
`ifndef MIDI_PARSER_RUNNING_STATUS_EN
        have = 0;
`endif
      end
    end
    stim.delete();
  endtask

  // Modes: 0 always ready, 1 random ready, 2 ten-cycle stall on first event, 3 never ready.
  task automatic run(input int mode, input int max_cycles);
    int   stall_left;
    bit   prev_held, popped;
    ev_t  held_v, cur;
    obs_q.delete();
    pops = 0; first_pop = -1; last_pop = -1; valid_cnt = 0; first_valid = -1;
    stall_viol = 0; stall_cycles = 0; timed_out = 0;
    stall_left = 10; prev_held = 0; held_v = '0;
    for (int n = 0; ; n++) begin
      if (n >= max_cycles) begin timed_out = 1; break; end
      fifo_empty = (fq.size() == 0);
      fifo_dout  = fifo_empty ? 8'h00 : fq[0];
      case (mode)
        1:       evt_ready = 1'($urandom_range(0, 1));
        2:       evt_ready = !(evt_valid && stall_left > 0);
        3:       evt_ready = 1'b0;
        default: evt_ready = 1'b1;
      endcase
      if (mode == 2 && !evt_ready) stall_left--;
      #1;
      cur = {evt_type, evt_channel, evt_data1, evt_data2};
      if (prev_held && (cur !== held_v || evt_valid !== 1'b1)) stall_viol++;
      if (fifo_empty && (!evt_valid || mode == 3)) break;
      popped = fifo_rd_en;
      if (popped) begin
        if (first_pop < 0) first_pop = n;
        last_pop = n;
      end
      if (evt_valid) begin
        valid_cnt++;
        if (first_valid < 0) first_valid = n;
      end
      if (evt_valid && !evt_ready) begin
        stall_cycles++;
        if (fifo_rd_en !== 1'b0) stall_viol++;
      end
      prev_held = evt_valid && !evt_ready;
      held_v    = cur;
      if (evt_valid && evt_ready) obs_q.push_back(cur);
      @(posedge clk); #1;
      if (popped) begin
        void'(fq.pop_front());
        pops++;
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; fifo_empty = 1'b1; evt_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    fq.delete();
    stim.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1; fifo_empty = 1'b0; fifo_dout = 8'h90; evt_ready = 1'b1;
    #1;
    checks++;
    if (fifo_rd_en !== 1'b0) begin
      failures++; $display("FAIL reset_rd_en: got %b expected 0", fifo_rd_en);
    end
    @(posedge clk); #1;
    checks++;
    if (evt_valid !== 1'b0) begin
      failures++; $display("FAIL reset_valid: got %b expected 0", evt_valid);
    end
    checks++;
    if ({evt_type, evt_channel, evt_data1, evt_data2} !== 21'd0) begin
      failures++;
      $display("FAIL reset_fields: got %h expected 0", {evt_type, evt_channel, evt_data1, evt_data2});
    end
    do_reset();
    load(8'h90); load(8'h40);
    run(0, 200);
    do_reset();
    load(8'h50); load(8'h60);
    run(0, 200);
    checks++;
    if (obs_q.size() != 0 || pops != 2) begin
      failures++;
      $display("FAIL reset_mid_msg: got events=%0d pops=%0d expected 0 and 2", obs_q.size(), pops);
    end
    do_reset();
    load(8'h91); load(8'h3C); load(8'h64);
    run(3, 200);
    checks++;
    if (evt_valid !== 1'b1) begin
      failures++; $display("FAIL stall_before_reset: got valid=%b expected 1", evt_valid);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (evt_valid !== 1'b0) begin
      failures++; $display("FAIL reset_mid_stall: got valid=%b expected 0", evt_valid);
    end
    do_reset();
  endtask

  task automatic test_note_on();
    ev_t want;
    do_reset();
    load(8'h91); load(8'h3C); load(8'h64);
    model();
    run(0, 200);
    want = {3'd1, 4'd1, 7'h3C, 7'h64};
    checks++;
    if (obs_q.size() != 1 || exp_q.size() != 1 || obs_q[0] !== want || exp_q[0] !== want) begin
      failures++;
      $display("FAIL note_on: got n=%0d ev=%h expected 1 ev=%h", obs_q.size(),
               (obs_q.size() > 0) ? obs_q[0] : ev_t'('0), want);
    end
    checks++;
    if (valid_cnt != 1 || first_valid != last_pop + 1) begin
      failures++;
      $display("FAIL note_on_timing: got valid_cycles=%0d at %0d expected 1 at %0d",
               valid_cnt, first_valid, last_pop + 1);
    end
    checks++;
    if (timed_out || pops != 3) begin
      failures++; $display("FAIL note_on_pops: got %0d timeout=%0b expected 3", pops, timed_out);
    end
    do_reset();
    load(8'h95); load(8'h22); load(8'h00);
    run(0, 200);
    want = {3'd0, 4'd5, 7'h22, 7'h00};
    checks++;
    if (obs_q.size() != 1 || obs_q[0] !== want) begin
      failures++;
      $display("FAIL vel0_note_off: got n=%0d ev=%h expected 1 ev=%h", obs_q.size(),
               (obs_q.size() > 0) ? obs_q[0] : ev_t'('0), want);
    end
  endtask

  task automatic test_running_status();
    int want_n;
    do_reset();
    load(8'h90); load(8'h40); load(8'h7F); load(8'h40); load(8'h00);
    model();
    run(0, 200);
`ifdef MIDI_PARSER_RUNNING_STATUS_EN
    want_n = 2;
`else
    want_n = 1;
`endif
    checks++;
    if (obs_q.size() != want_n || exp_q.size() != want_n) begin
      failures++;
      $display("FAIL running_status_count: got %0d expected %0d", obs_q.size(), want_n);
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          failures++;
          $display("FAIL running_status_ev%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_realtime_sysex();
    ev_t want;
    do_reset();
    load(8'hB2); load(8'hF8); load(8'h07); load(8'hFE); load(8'h64);
    run(0, 200);
    want = {3'd3, 4'd2, 7'h07, 7'h64};
    checks++;
    if (obs_q.size() != 1 || obs_q[0] !== want || pops != 5) begin
      failures++;
      $display("FAIL realtime: got n=%0d ev=%h pops=%0d expected 1 ev=%h pops=5", obs_q.size(),
               (obs_q.size() > 0) ? obs_q[0] : ev_t'('0), pops, want);
    end
    do_reset();
    load(8'hC5); load(8'h0A); load(8'hF0); load(8'h01); load(8'h02); load(8'hF7); load(8'h0B);
    run(0, 200);
    want = {3'd4, 4'd5, 7'h0A, 7'h00};
    checks++;
    if (obs_q.size() != 1 || obs_q[0] !== want || pops != 7) begin
      failures++;
      $display("FAIL sysex: got n=%0d ev=%h pops=%0d expected 1 ev=%h pops=7", obs_q.size(),
               (obs_q.size() > 0) ? obs_q[0] : ev_t'('0), pops, want);
    end
  endtask

  task automatic test_backpressure();
    ev_t w0, w1;
    do_reset();
    load(8'h92); load(8'h30); load(8'h50); load(8'h92); load(8'h31); load(8'h50);
    run(2, 300);
    w0 = {3'd1, 4'd2, 7'h30, 7'h50};
    w1 = {3'd1, 4'd2, 7'h31, 7'h50};
    checks++;
    if (stall_viol != 0 || stall_cycles != 10) begin
      failures++;
      $display("FAIL stall_hold: got violations=%0d stall_cycles=%0d expected 0 and 10",
               stall_viol, stall_cycles);
    end
    checks++;
    if (obs_q.size() != 2 || pops != 6 || timed_out) begin
      failures++;
      $display("FAIL stall_count: got n=%0d pops=%0d expected 2 and 6", obs_q.size(), pops);
    end else begin
      checks++;
      if (obs_q[0] !== w0 || obs_q[1] !== w1) begin
        failures++;
        $display("FAIL stall_events: got %h %h expected %h %h", obs_q[0], obs_q[1], w0, w1);
      end
    end
  endtask

  task automatic test_channel_mask();
    ev_t want;
    do_reset();
    load(8'h93); load(8'h30); load(8'h50); load(8'h90); load(8'h30); load(8'h50);
    run(0, 200);
    want = {3'd1, 4'd0, 7'h30, 7'h50};
    checks++;
    if (obs_q.size() != 1 || obs_q[0] !== want || pops != 6) begin
      failures++;
      $display("FAIL channel_mask: got n=%0d ev=%h pops=%0d expected 1 ev=%h pops=6",
               obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : ev_t'('0), pops, want);
    end
  endtask

  task automatic test_back_to_back();
    int nbytes;
    do_reset();
    nbytes = 0;
`ifdef MIDI_PARSER_RUNNING_STATUS_EN
    load(8'h90); nbytes++;
`endif
    for (int k = 0; k < 8; k++) begin
`ifndef MIDI_PARSER_RUNNING_STATUS_EN
      load(8'h90 + 8'($urandom_range(0, 2))); nbytes++;
`endif
      load(8'($urandom_range(0, 127)));
      load(8'($urandom_range(1, 127)));
      nbytes += 2;
    end
    model();
    run(0, 400);
    checks++;
    if (pops != nbytes || last_pop - first_pop + 1 != nbytes) begin
      failures++;
      $display("FAIL b2b_throughput: got pops=%0d span=%0d expected %0d", pops,
               last_pop - first_pop + 1, nbytes);
    end
    checks++;
    if (obs_q.size() != 8 || exp_q.size() != 8) begin
      failures++;
      $display("FAIL b2b_count: got %0d expected 8", obs_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          failures++; $display("FAIL b2b_ev%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 30; it++) begin
      int len;
      do_reset();
      len = $urandom_range(1, 40);
      for (int k = 0; k < len; k++) begin
        int         r;
        logic [7:0] b;
        r = $urandom_range(0, 99);
        if (r < 8)       b = 8'hF8 + 8'($urandom_range(0, 7));
        else if (r < 12) b = 8'hF0 + 8'($urandom_range(0, 7));
        else if (r < 35) b = 8'h80 + 8'($urandom_range(0, 111));
        else if (r < 42) b = 8'h00;
        else             b = 8'($urandom_range(0, 127));
        load(b);
      end
      model();
      run(1, 2000);
      checks++;
      if (timed_out || pops != len || stall_viol != 0) begin
        failures++;
        $display("FAIL rand%0d_flow: got pops=%0d viol=%0d timeout=%0b expected %0d 0 0",
                 it, pops, stall_viol, timed_out, len);
      end
      checks++;
      if (obs_q.size() != exp_q.size()) begin
        failures++;
        $display("FAIL rand%0d_count: got %0d expected %0d", it, obs_q.size(), exp_q.size());
      end else begin
        foreach (exp_q[i]) begin
          checks++;
          if (obs_q[i] !== exp_q[i]) begin
            failures++;
            $display("FAIL rand%0d_ev%0d: got %h expected %h", it, i, obs_q[i], exp_q[i]);
          end
        end
      end
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    reset = 1'b1; fifo_dout = 8'h00; fifo_empty = 1'b1; evt_ready = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_note_on();
    test_running_status();
    test_realtime_sysex();
    test_backpressure();
    test_channel_mask();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
